// File: rtl/mgmt_wb_pkg.sv
// mgmt_wb_pkg: shared types and helpers for the management Wishbone fabric
package mgmt_wb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;
  function automatic int clog2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction
endpackage

// File: rtl/mgmt_wb_fabric_if.sv
// mgmt_wb_fabric_if: core-side and slave-side Wishbone signals of the fabric
interface mgmt_wb_fabric_if #(
  parameter int NUM_SLAVES = 4,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic                     m_cyc, m_stb, m_we, m_ack, m_err;
  logic [DW/8-1:0]          m_sel;
  logic [AW-1:0]            m_adr;
  logic [DW-1:0]            m_wdat, m_rdat;
  logic [NUM_SLAVES-1:0]    s_cyc, s_stb, s_ack, s_iena;
  logic                     s_we;
  logic [DW/8-1:0]          s_sel;
  logic [AW-1:0]            s_adr;
  logic [DW-1:0]            s_wdat;
  logic [NUM_SLAVES*DW-1:0] s_rdat;
  modport master (output m_cyc, m_stb, m_we, m_sel, m_adr, m_wdat, input m_ack, m_err, m_rdat);
  modport slave (input s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat, s_iena, output s_ack, s_rdat);
  modport fabric (
    input  m_cyc, m_stb, m_we, m_sel, m_adr, m_wdat, s_ack, s_rdat,
    output m_ack, m_err, m_rdat, s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat, s_iena
  );
endinterface

// File: rtl/mgmt_wb_decode.sv
// mgmt_wb_decode: base/mask address decode, lowest enabled matching slave wins
module mgmt_wb_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int AW = 32,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK = '0
) (
  input  logic [AW-1:0]         adr,
  input  logic [NUM_SLAVES-1:0] slave_en,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic [2:0]            idx
);
  always_comb begin
    hit = 1'b0;
    onehot = '0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (slave_en[i] && (adr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit = 1'b1;
        onehot = '0;
        onehot[i] = 1'b1;
        idx = 3'(i);
      end
  end
endmodule

// File: rtl/mgmt_wb_fabric.sv
// mgmt_wb_fabric: registered-decode Wishbone fabric with bus timeout and error counter
module mgmt_wb_fabric import mgmt_wb_pkg::*; #(
  parameter int NUM_SLAVES = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE = {32'h2100_0000, 32'h2000_0000, 32'h2600_0000, 32'h3000_0000},
  parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK = {32'hFFF0_0000, 32'hFFF0_0000, 32'hFF00_0000, 32'hF000_0000}
) (
  input  logic                  core_clk,
  input  logic                  core_rstn,
  mgmt_wb_fabric_if.fabric      bus,
  input  logic [NUM_SLAVES-1:0] slave_en,
  output logic                  timeout,
  output logic [2:0]            timeout_slv,
  output logic [7:0]            err_cnt
);
  localparam int CW = clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [NUM_SLAVES-1:0] sel_oh, dec_oh;
  logic [2:0] idx, dec_idx;
  logic [DW-1:0] rdata;
  logic resp_ack, resp_to, hit, req, ack, to_hit;
  logic [7:0] err_inc;
  mgmt_wb_decode #(.NUM_SLAVES(NUM_SLAVES), .AW(AW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_dec (
    .adr(bus.m_adr), .slave_en(slave_en), .hit(hit), .onehot(dec_oh), .idx(dec_idx)
  );
  assign req = bus.m_cyc & bus.m_stb;
  assign ack = |(bus.s_ack & sel_oh);
  assign to_hit = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES) && !ack;
  assign err_inc = err_cnt + {7'd0, err_cnt != 8'hFF};
  always_ff @(posedge core_clk) state <= !core_rstn ? IDLE : state_n;
  always_comb
    state_n = state == IDLE   ? (req ? (hit ? ACCESS : RESP) : IDLE)
            : state == ACCESS ? (!bus.m_cyc ? IDLE : (ack || to_hit) ? RESP : ACCESS)
            : IDLE;
  always_comb begin
    bus.s_cyc = state == ACCESS ? sel_oh : '0;
    bus.s_stb = state == ACCESS ? sel_oh : '0;
    bus.s_iena = state == ACCESS ? sel_oh : '0;
    bus.m_ack = state == RESP && resp_ack;
    bus.m_err = state == RESP && !resp_ack;
    bus.m_rdat = state == RESP ? rdata : '0;
    timeout = state == RESP && resp_to;
  end
  // error read data is preloaded at request time so a timeout only has to flag the response
  always_ff @(posedge core_clk)
    if (!core_rstn) begin
      cnt <= '0;
      sel_oh <= '0;
      idx <= '0;
      rdata <= '0;
      resp_ack <= 1'b0;
      resp_to <= 1'b0;
      bus.s_we <= 1'b0;
      bus.s_sel <= '0;
      bus.s_adr <= '0;
      bus.s_wdat <= '0;
      timeout_slv <= '0;
      err_cnt <= '0;
    end else begin
      cnt <= state == ACCESS ? cnt + 1'b1 : '0;
      resp_to <= 1'b0;
      if (state == IDLE && req) begin
        bus.s_we <= bus.m_we;
        bus.s_sel <= bus.m_sel;
        bus.s_adr <= bus.m_adr;
        bus.s_wdat <= bus.m_wdat;
        sel_oh <= dec_oh;
        idx <= dec_idx;
        resp_ack <= 1'b0;
        rdata <= bus.m_we ? '0 : DW'(ERR_RDATA);
        if (!hit) err_cnt <= err_inc;
      end
      if (state == ACCESS && ack) begin
        resp_ack <= 1'b1;
        rdata <= bus.s_we ? '0 : bus.s_rdat[idx*DW +: DW];
      end
      if (state == ACCESS && bus.m_cyc && to_hit) begin
        resp_to <= 1'b1;
        timeout_slv <= idx;
        err_cnt <= err_inc;
      end
    end
endmodule
